// File: rtl/disp_pkg.sv
// Shared constants for the status-word 7-segment scanner: message codes and glyphs.
// Pure definitions, no logic, no latency.
// No flow control; consumers are combinational lookups.
package disp_pkg;

  typedef logic [2:0] msg_t;
  typedef logic [1:0] char_idx_t;
  typedef logic [6:0] glyph_t;

  localparam msg_t MSG_BLANK = 3'b000;
  localparam msg_t MSG_PARE  = 3'b001;
  localparam msg_t MSG_OCUP  = 3'b010;
  localparam msg_t MSG_SIGA  = 3'b011;
  localparam msg_t MSG_ERRO  = 3'b100;

  // Active-low segments, bit 6 = a ... bit 0 = g.
  localparam glyph_t GLYPH_P     = 7'b0011000;
  localparam glyph_t GLYPH_A     = 7'b0001000;
  localparam glyph_t GLYPH_R     = 7'b1111010;
  localparam glyph_t GLYPH_E     = 7'b0110000;
  localparam glyph_t GLYPH_O     = 7'b0000001;
  localparam glyph_t GLYPH_C     = 7'b0110001;
  localparam glyph_t GLYPH_U     = 7'b1000001;
  localparam glyph_t GLYPH_S     = 7'b0100100;
  localparam glyph_t GLYPH_I     = 7'b1111001;
  localparam glyph_t GLYPH_G     = 7'b0000100;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_glyph_rom.sv
// Maps (message code, character position 0..3) to the active-low glyph of that character.
// Purely combinational, zero latency.
// No flow control; undefined codes yield a blank glyph.
module seg_glyph_rom
  import disp_pkg::*;
(
  input  msg_t      code,
  input  char_idx_t pos,
  output glyph_t    glyph
);

  // Word lookup; position 0 is the leftmost character of the word.
  always_comb begin
    glyph = GLYPH_BLANK;
    case (code)
      MSG_PARE: begin
        case (pos)
          2'd0:    glyph = GLYPH_P;
          2'd1:    glyph = GLYPH_A;
          2'd2:    glyph = GLYPH_R;
          default: glyph = GLYPH_E;
        endcase
      end
      MSG_OCUP: begin
        case (pos)
          2'd0:    glyph = GLYPH_O;
          2'd1:    glyph = GLYPH_C;
          2'd2:    glyph = GLYPH_U;
          default: glyph = GLYPH_P;
        endcase
      end
      MSG_SIGA: begin
        case (pos)
          2'd0:    glyph = GLYPH_S;
          2'd1:    glyph = GLYPH_I;
          2'd2:    glyph = GLYPH_G;
          default: glyph = GLYPH_A;
        endcase
      end
      MSG_ERRO: begin
        case (pos)
          2'd0:    glyph = GLYPH_E;
          2'd1:    glyph = GLYPH_R;
          2'd2:    glyph = GLYPH_R;
          default: glyph = GLYPH_O;
        endcase
      end
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode scanner showing a 4-letter status word with guard blanking and blink.
// seg/an/frame_done registered: 1 cycle after the internal scan state; msg applied at frame wrap.
// No backpressure; msg is sampled only on the wrap tick, changes in between are ignored.
module seg_scan_display
  import disp_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        msg,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  msg_t          msg_q;
  logic [FW-1:0] fcnt;
  logic          blink_on;

  logic          tick;
  logic          wrap;
  logic          frame_last;
  logic [IW:0]   rel;
  logic          lead_blank;
  char_idx_t     pos;
  glyph_t        rom_glyph;
  glyph_t        cur_glyph;
  logic          in_guard;
  logic [IW-1:0] an_sel;
  logic [DIGITS-1:0] an_next;

  assign tick       = (pcnt == PW'(CLK_DIV - 1));
  assign wrap       = tick && (idx == IW'(DIGITS - 1));
  assign frame_last = (fcnt == FW'(BLINK_FRAMES - 1));

  // Word sits in the rightmost four slots; a negative offset (MSB set) means a leading blank slot.
  assign rel        = {1'b0, idx} - (IW+1)'(DIGITS - 4);
  assign lead_blank = rel[IW];
  assign pos        = rel[1:0];

  seg_glyph_rom u_rom (
    .code  (msg_q),
    .pos   (pos),
    .glyph (rom_glyph)
  );

  assign cur_glyph = lead_blank ? GLYPH_BLANK : rom_glyph;
  assign in_guard  = ({1'b0, pcnt} < (PW+1)'(GUARD));
  assign an_sel    = IW'(DIGITS - 1) - idx;

  // Anode for the current slot; dark during guard, blink-off phase or for blank characters.
  always_comb begin
    an_next = '1;
    if (!(in_guard || (blink_en && !blink_on) || (cur_glyph == GLYPH_BLANK))) begin
      an_next[an_sel] = 1'b0;
    end
  end

  // Prescaler and slot index: one slot per CLK_DIV cycles, wrapping after the last digit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= wrap ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Frame-boundary state: message latch, frame counter and blink phase advance only on wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      msg_q    <= MSG_BLANK;
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (wrap) begin
      msg_q <= msg;
      fcnt  <= frame_last ? '0 : fcnt + 1'b1;
      if (frame_last) begin
        blink_on <= ~blink_on;
      end
    end
  end

  // Registered pin drivers so segments and anodes switch together, glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= GLYPH_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= cur_glyph;
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule
